// File: rtl/multiplier_pkg.sv
// Shared constants and types for the iterative shift-add multiplier.
package multiplier_pkg;

    localparam int W     = 32;
    localparam int CNT_W = 6;

    typedef logic [CNT_W-1:0] step_t;

    localparam step_t STEPS = step_t'(32);
    localparam step_t LAST  = step_t'(33);

    typedef enum logic [1:0] {
        PH_LOAD,
        PH_STEP,
        PH_HOLD
    } phase_e;

    // Counter value 0 loads y, 1..STEPS accumulate, LAST holds the result.
    function automatic phase_e phase_of(input step_t s);
        if (s == '0) begin
            return PH_LOAD;
        end else if (s == LAST) begin
            return PH_HOLD;
        end else begin
            return PH_STEP;
        end
    endfunction

endpackage

// File: rtl/multiplier_mul_step.sv
// One shift-add step: (W+1)-bit sum of the extended upper half and the
// conditionally selected, optionally negated, extended multiplicand.
module mul_step
    import multiplier_pkg::*;
(
    input  logic [W-1:0] hi,
    input  logic [W-1:0] x,
    input  logic         b,
    input  logic         sgn,
    input  logic         neg,
    output logic [W:0]   sum
);

    logic [W:0] ext_hi;
    logic [W:0] ext_x;
    logic [W:0] addend;

    always_comb begin
        ext_hi = {sgn & hi[W-1], hi};
        ext_x  = {sgn & x[W-1], x};
        addend = '0;
        if (b) begin
            // The top multiplier bit carries negative weight in two's complement.
            addend = neg ? (~ext_x + 1'b1) : ext_x;
        end
        sum = ext_hi + addend;
    end

endmodule

// File: rtl/multiplier.sv
// Iterative radix-2 32x32->64 multiplier with run/stall handshake; signed or
// unsigned operands, one multiplier bit retired per clock.
module multiplier
    import multiplier_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    output logic           stall,
    input  logic           op_unsigned,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] z
);

    step_t          s_reg;
    logic [2*W-1:0] p_reg;
    logic [W:0]     sum;
    logic           neg;

    assign neg   = ~op_unsigned & (s_reg == STEPS);
    assign stall = run & (s_reg != LAST);
    assign z     = p_reg;

    mul_step u_step (
        .hi  (p_reg[2*W-1:W]),
        .x   (x),
        .b   (p_reg[0]),
        .sgn (~op_unsigned),
        .neg (neg),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg <= '0;
            p_reg <= '0;
        end else if (!run) begin
            // P is left alone so z keeps showing the last product.
            s_reg <= '0;
        end else begin
            if (s_reg != LAST) begin
                s_reg <= s_reg + 1'b1;
            end
            case (phase_of(s_reg))
                PH_LOAD: p_reg <= {{W{1'b0}}, y};
                PH_STEP: p_reg <= {sum, p_reg[W-1:1]};
                default: p_reg <= p_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench: randomized and directed multiplies against a
// cycle-count/arithmetic reference model.
module tb_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        stall;
    logic        op_unsigned;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] z;

    int checks = 0;
    int errors = 0;

    multiplier dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .stall       (stall),
        .op_unsigned (op_unsigned),
        .x           (x),
        .y           (y),
        .z           (z)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic u);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (u) begin
            return {32'h0, a} * {32'h0, b};
        end
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return 64'(sa * sb);
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: counts edges with run high; the product is exact after 33 of them.
    int          edges = 0;
    logic [63:0] z_exp = '0;
    bit          z_known = 1'b0;
    bit          live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            live    <= 1'b1;
            edges   <= 0;
            z_exp   <= '0;
            z_known <= 1'b1;
        end else if (!run) begin
            edges <= 0;
        end else begin
            if (edges == 0) z_known <= 1'b0;
            if (edges < 33) edges <= edges + 1;
            if (edges == 32) begin
                z_exp   <= ref_mul(x, y, op_unsigned);
                z_known <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            checks++;
            if (stall !== (run && edges < 33)) begin
                errors++;
                $display("FAIL stall_cycle t=%0t actual=%b expected=%b", $time, stall,
                         (run && edges < 33));
            end
            if (z_known) begin
                checks++;
                if (z !== z_exp) begin
                    errors++;
                    $display("FAIL z_cycle t=%0t actual=%h expected=%h", $time, z, z_exp);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the idle edge that follows.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic u,
                         input bit has_lit, input logic [63:0] lit);
        int n;
        run = 1'b1;
        x = a;
        y = b;
        op_unsigned = u;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 40) begin
                errors++;
                $display("FAIL stall_timeout actual=%0d required=33", n);
                break;
            end
        end
        if (has_lit) begin
            checks++;
            if (n != 33) begin
                errors++;
                $display("FAIL stall_len actual=%0d required=33", n);
            end
            check64("z_literal", z, lit);
            check64("model_literal", ref_mul(a, b, u), lit);
            $display("op x=%h y=%h u=%0d z=%h stall_cycles=%0d", a, b, u, z, n);
        end
        @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                                 32'h7FFFFFFF, 32'h2};

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ru;
        rst = 1'b1;
        run = 1'b0;
        op_unsigned = 1'b1;
        x = '0;
        y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check64("reset_z", z, 64'h0);
        check64("reset_stall", {63'h0, stall}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'hFFFFFFFE_00000001);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'h00000000_00000001);
        do_op(32'hFFFFFFFE, 32'h00000003, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFA);
        do_op(32'h80000000, 32'h80000000, 1'b0, 1'b1, 64'h40000000_00000000);
        do_op(32'h80000000, 32'h00000002, 1'b0, 1'b1, 64'hFFFFFFFF_00000000);
        do_op(32'h80000000, 32'h00000002, 1'b1, 1'b1, 64'h00000001_00000000);

        // Reset asserted mid-operation while run stays high.
        run = 1'b1;
        x = 32'h12345678;
        y = 32'h9ABCDEF0;
        op_unsigned = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check64("rst_run_z", z, 64'h0);
        check64("rst_run_stall", {63'h0, stall}, 64'h1);
        #1 rst = 1'b0;
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check64("post_rst_stall", {63'h0, stall}, 64'h0);
        @(posedge clk);
        #1;

        // Abort after 10 cycles, then a fresh operation after one idle edge.
        run = 1'b1;
        x = 32'hDEADBEEF;
        y = 32'hCAFEF00D;
        op_unsigned = 1'b0;
        repeat (10) @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        #1;
        do_op(32'h7, 32'h6, 1'b1, 1'b1, 64'h00000000_0000002A);

        for (int i = 0; i < 2500; i++) begin
            ra = (($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom);
            rb = (($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom);
            ru = 1'($urandom_range(0, 1));
            do_op(ra, rb, ru, 1'b0, 64'h0);
            if (i % 250 == 0)
                $display("rand op %0d x=%h y=%h u=%0d z=%h", i, ra, rb, ru, z);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Iterative 32x32 -> 64-bit integer multiplier for the RISC5/Oberon integer datapath.
- Supports signed (two's complement) and unsigned operands.
- Uses a run/stall handshake: the CPU holds `run` high and freezes while `stall` is high.
- Radix-2 shift-add, one multiplier bit per cycle; `z` is a registered result.

Parameters:
- W, 32: operand width; result width is 2*W. All values below assume W=32.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  operation request; held high until `stall` is seen low.
- stall  out  1  high while the product is not yet valid.
- op_unsigned  in  1  1 = unsigned multiply, 0 = signed.
- x  in  32  multiplicand; stable while `run`=1.
- y  in  32  multiplier; stable while `run`=1.
- z  out  64  product; valid in the cycle where `run`=1 and `stall`=0.

Behaviour:
- State:
  - step counter S, 6 bits.
  - product register P, 64 bits = {hi[31:0], lo[31:0]}.
  - z = P.
- Reset (rst=1 at a clk edge): S<=0, P<=0. Therefore z=0, and stall=0 while run=0. rst overrides run.
- stall = run & (S != 33). Combinational; no stall when idle.
- run=0 at an edge: S<=0; P holds, so z keeps the last result.
- run=1 at an edge: S<=S+1 while S<33; S saturates at 33 while run stays high.
- Datapath:
  - S=0 (first edge of an operation): P <= {32'h0, y}.
  - S=1..32 (step k = S-1, 0..31): b = P[0].
    - addend = b ? ext(x) : 0, as 33 bits.
    - ext = sign-extend if op_unsigned=0, zero-extend if op_unsigned=1.
    - Signed and k=31: addend negated (subtract x·y[31] weight).
    - sum33 = ext(hi) + addend, using the same extension rule for hi.
    - P <= {sum33, P[31:1]}.
  - S=33: P holds.
- Latency: with run rising at cycle 0, stall is high for cycles 0..32. Cycle 33 has stall=0 and z = exact product mod 2^64.
- Results:
  - Unsigned: z = x*y.
  - Signed: z = $signed(x)*$signed(y), 64-bit two's complement.
- run dropping before stall falls: operation aborts, S<=0, P contents undefined until the next full operation.
- Back-to-back operations: run must be low for ≥1 clk edge between operations (that edge resets S). The next operation's z is valid 33 cycles after run re-rises.
- x, y, op_unsigned are sampled each step. Changing them mid-operation gives an undefined result; this is not checked.
- No overflow flag; the full 64-bit result is always produced.

Decomposition:
- Shared package: W=32, STEPS=32, LAST=33 (counter terminal value), step-counter width 6.
- Optional sub-module `mul_step`: combinational 33-bit add/sub with sign/zero extension and negate control, instantiated once.
- Counter and P register stay in `multiplier`.

Test Plan:
- Unsigned x=0xFFFFFFFF, y=0xFFFFFFFF -> z=0xFFFFFFFE_00000001; stall high exactly 33 cycles after run rises, low on the 34th.
- Signed x=0xFFFFFFFF, y=0xFFFFFFFF -> z=0x00000000_00000001. Signed x=0xFFFFFFFE (-2), y=3 -> z=0xFFFFFFFF_FFFFFFFA.
- Signed x=0x80000000, y=0x80000000 -> z=0x40000000_00000000. Signed x=0x80000000, y=2 -> z=0xFFFFFFFF_00000000. Unsigned x=0x80000000, y=2 -> z=0x00000001_00000000.
- Reset: rst=1 with run=1 -> next cycle S=0, z=0. After rst falls with run=0, stall=0.
- Abort: drop run after 10 cycles, then start unsigned x=7, y=6 with one idle cycle -> z=0x00000000_0000002A after 33 stall cycles.
- Randomized: ≥2500 random (x, y, op_unsigned) triples, back-to-back with one idle cycle -> z matches the reference product every time.
